// File: rtl/pe_array_pkg.sv
// Shared types and arithmetic helpers for the streaming PE array.
// Holds the sequencing state encoding and the accumulator clamp used by every PE.
package pe_array_pkg;

    localparam int PE_ROWS   = 15;
    localparam int PE_COLS   = 15;
    localparam int PE_DATA_W = 8;
    localparam int PE_ACC_W  = 20;
    localparam int COL_W     = $clog2(PE_COLS);

    // Wide enough to hold any supported accumulator plus a product without overflow.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Adds two sign-extended operands and clamps to the signed range of acc_w bits.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             acc_w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pe_array_stream_pe_mac.sv
// One signed multiply-accumulate element with a saturating accumulator.
// Updates one cycle after en; clr has priority over en.
module pe_mac
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_W,
    parameter int ACC_WIDTH  = PE_ACC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] actn,
    input  logic signed [DATA_WIDTH-1:0] filt,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_nxt;

    assign prod    = actn * filt;
    assign acc_nxt = ACC_WIDTH'(sat_add(SAT_W'(acc), SAT_W'(prod), ACC_WIDTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/pe_array_stream.sv
// ROWS x COLS signed MAC grid: streams k_len activation/filter beats, then drains one column per beat.
// Handshake flags decode from registered state only; out_data is a mux of registered accumulators.
module pe_array_stream
    import pe_array_pkg::*;
#(
    parameter int  ROWS       = PE_ROWS,
    parameter int  COLS       = PE_COLS,
    parameter int  DATA_WIDTH = PE_DATA_W,
    parameter int  ACC_WIDTH  = PE_ACC_W,
    localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [15:0]                         k_len,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ROWS-1:0][DATA_WIDTH-1:0]     actn_in,
    input  logic [COLS-1:0][DATA_WIDTH-1:0]     filt_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ROWS-1:0][ACC_WIDTH-1:0]      out_data,
    output logic [CW-1:0]                       out_col,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done
);

    state_t      state_q, state_d;
    logic [15:0] k_q;
    logic [15:0] beat_q;
    logic [CW-1:0] col_q;
    logic        acc_clr;
    logic        mac_fire;
    logic        drain_fire;
    logic        col_is_last;

    logic signed [ACC_WIDTH-1:0] acc_grid [ROWS][COLS];

    assign col_is_last = (col_q == CW'(COLS - 1));

    always_comb begin
        state_d    = state_q;
        acc_clr    = 1'b0;
        mac_fire   = 1'b0;
        drain_fire = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_clr = 1'b1;
                    state_d = (k_len != 16'd0) ? ST_MAC : ST_DRAIN;
                end
            end
            ST_MAC: begin
                in_ready = 1'b1;
                mac_fire = in_valid;
                if (in_valid && (beat_q == k_q - 16'd1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid  = 1'b1;
                out_last   = col_is_last;
                drain_fire = out_ready;
                if (out_ready && col_is_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            if (acc_clr) begin
                k_q    <= k_len;
                beat_q <= '0;
            end else if (mac_fire) begin
                beat_q <= beat_q + 16'd1;
            end
            // Column pointer rests at zero outside DRAIN so every drain starts at column 0.
            if (state_q != ST_DRAIN) begin
                col_q <= '0;
            end else if (drain_fire) begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pe_mac #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .clr  (acc_clr),
                .en   (mac_fire),
                .actn (actn_in[r]),
                .filt (filt_in[c]),
                .acc  (acc_grid[r][c])
            );
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            out_data[r] = acc_grid[r][col_q];
        end
    end

    assign out_col = col_q;

endmodule

// File: tb/tb_pe_array_stream.sv
// Directed-plus-random bench for pe_array_stream with an integer reference of the accumulated grid.
module tb_pe_array_stream;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int CW   = 2;
    localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [15:0]               k_len;
    logic                      in_valid;
    logic                      in_ready;
    logic [ROWS-1:0][DW-1:0]   actn_in;
    logic [COLS-1:0][DW-1:0]   filt_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [ROWS-1:0][AW-1:0]   out_data;
    logic [CW-1:0]             out_col;
    logic                      out_last;
    logic                      busy;
    logic                      done;

    int n_chk  = 0;
    int n_fail = 0;
    longint model [ROWS][COLS];

    pe_array_stream #(
        .ROWS (ROWS), .COLS (COLS), .DATA_WIDTH (DW), .ACC_WIDTH (AW)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .k_len (k_len),
        .in_valid (in_valid), .in_ready (in_ready),
        .actn_in (actn_in), .filt_in (filt_in),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data), .out_col (out_col), .out_last (out_last),
        .busy (busy), .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_column(input string tag, input int c);
        for (int r = 0; r < ROWS; r++) begin
            chk(tag, 64'($signed(out_data[r])), model[r][c]);
        end
    endtask

    // mode: 0 const 2/3, 1 lane identity, 2 127*127, 3 127*-128, 4 random
    task automatic run_op(input int k, input int mode, input bit rnd_valid, input bit stall_drain);
        int beats;
        int cyc;
        int av [ROWS];
        int fv [COLS];
        start = 1'b1;
        k_len = 16'(k);
        step();
        start = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = 0;
        chk("busy_after_start", 64'(busy), 1);
        chk("in_ready_after_start", 64'(in_ready), (k > 0) ? 1 : 0);
        beats = 0;
        cyc   = 0;
        while (beats < k && cyc < 2000) begin
            for (int r = 0; r < ROWS; r++) begin
                case (mode)
                    0: av[r] = 2;
                    1: av[r] = r + 1;
                    2, 3: av[r] = 127;
                    default: av[r] = int'($urandom_range(0, 255)) - 128;
                endcase
                actn_in[r] = DW'(av[r]);
            end
            for (int c = 0; c < COLS; c++) begin
                case (mode)
                    0: fv[c] = 3;
                    1: fv[c] = -(c + 1);
                    2: fv[c] = 127;
                    3: fv[c] = -128;
                    default: fv[c] = int'($urandom_range(0, 255)) - 128;
                endcase
                filt_in[c] = DW'(fv[c]);
            end
            in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc % 7 == 0) chk("in_ready_mac", 64'(in_ready), 1);
            step();
            cyc++;
            if (in_valid) begin
                beats++;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) begin
                        model[r][c] = model[r][c] + longint'(av[r]) * longint'(fv[c]);
                        if (model[r][c] > ACC_MAX) model[r][c] = ACC_MAX;
                        if (model[r][c] < ACC_MIN) model[r][c] = ACC_MIN;
                    end
            end
        end
        in_valid = 1'b0;
        if (beats < k) chk("mac_timeout", beats, k);
        if (!rnd_valid) chk("mac_cycles", cyc, k);
        for (int c = 0; c < COLS; c++) begin
            chk("out_valid", 64'(out_valid), 1);
            chk("in_ready_drain", 64'(in_ready), 0);
            chk("out_col", 64'(out_col), c);
            chk("out_last", 64'(out_last), (c == COLS - 1) ? 1 : 0);
            chk_column("out_data", c);
            if (stall_drain && c == 1) begin
                out_ready = 1'b0;
                start     = 1'b1;
                in_valid  = 1'b1;
                repeat (3) begin
                    step();
                    chk("stall_out_valid", 64'(out_valid), 1);
                    chk("stall_out_col", 64'(out_col), 1);
                    chk_column("stall_out_data", 1);
                end
                start     = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            step();
        end
        chk("done_pulse", 64'(done), 1);
        chk("out_valid_done", 64'(out_valid), 0);
        step();
        chk("done_clear", 64'(done), 0);
        chk("busy_idle", 64'(busy), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 0);
        chk({tag, "_out_valid"}, 64'(out_valid), 0);
        chk({tag, "_out_last"}, 64'(out_last), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_out_col"}, 64'(out_col), 0);
        for (int r = 0; r < ROWS; r++) chk({tag, "_out_data"}, 64'(out_data[r]), 0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        actn_in   = '0;
        filt_in   = '0;
        repeat (2) step();
        chk_quiet("reset");
        rst = 1'b1;
        step();

        run_op(3, 0, 1'b0, 1'b0);
        run_op(1, 1, 1'b0, 1'b0);
        run_op(100, 2, 1'b0, 1'b0);
        run_op(100, 3, 1'b0, 1'b0);
        run_op(5, 4, 1'b1, 1'b1);
        run_op(0, 0, 1'b0, 1'b1);

        // Accumulators hold after done; in_valid in IDLE must not disturb them.
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        chk_column("idle_hold", 0);

        // Reset in the middle of a 4-beat accumulation.
        start = 1'b1;
        k_len = 16'd4;
        step();
        start    = 1'b0;
        actn_in  = {ROWS{8'sd5}};
        filt_in  = {COLS{8'sd7}};
        in_valid = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk_quiet("mid_mac_reset");
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        run_op(1, 4, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            run_op(int'($urandom_range(1, 20)), 4, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_array_stream.md
# pe_array_stream

Parametrised successor of the weight-broadcast PE array: a ROWS x COLS grid of signed MAC processing elements with its own sequencing FSM, valid/ready input streaming and column-serial output drain. Row r receives one activation per beat and column c receives one filter value per beat. After K accepted beats, PE(r,c) holds the saturated sum of actn[r]*filt[c]. The accumulated grid is then drained one column per output beat to the output-feature buffer. The block sits between the activation/filter buffers and the output buffer, replacing the externally sequenced control bundle with a start/done interface.

## Interface
- ROWS, 15, PE rows (activation lanes, output lanes)
- COLS, 15, PE columns (filter lanes, drain beats)
- DATA_WIDTH, 8, signed activation/filter width
- ACC_WIDTH, 20, signed accumulator width (must be >= 2*DATA_WIDTH)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin an operation; sampled only in IDLE
- k_len  in  16  MAC beats per operation; sampled with start
- in_valid  in  1  actn_in/filt_in beat valid
- in_ready  out  1  array accepts a beat
- actn_in  in  ROWS x DATA_WIDTH  signed activation per row
- filt_in  in  COLS x DATA_WIDTH  signed filter value per column
- out_valid  out  1  drain beat valid
- out_ready  in  1  downstream accepts drain beat
- out_data  out  ROWS x ACC_WIDTH  accumulators of column out_col, element r = PE(r,out_col)
- out_col  out  $clog2(COLS)  column index of current drain beat
- out_last  out  1  current drain beat is column COLS-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final drain beat accepted

## Operation
- FSM states: IDLE, MAC, DRAIN, DONE.
- IDLE: if start=1 and k_len>0, clear all accumulators, latch k_len, clear the beat counter, and go to MAC. If start=1 and k_len=0, clear all accumulators and go to DRAIN, which drains zeros.
- MAC: in_ready=1. An accepted beat (in_valid & in_ready) updates every PE in the same edge: acc <= sat(acc + actn_in[r]*filt_in[c]), and the beat counter increments. When the accepted beat is beat k_len-1, go to DRAIN, with out_col cleared.
- Arithmetic: the product is signed 2*DATA_WIDTH and is sign-extended to ACC_WIDTH+1 before the add. The result clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- DRAIN: out_valid=1, in_ready=0. On each out_valid & out_ready, out_col increments. out_last=1 when out_col=COLS-1. Acceptance of the last beat moves the FSM to DONE. out_data and out_col hold stable while out_valid=1 and out_ready=0.
- DONE: done=1 for exactly one cycle, then go to IDLE. Accumulators keep their values until the next start.
- start outside IDLE is ignored. in_valid outside MAC is ignored and causes no accumulator change.

## Timing
- Reset (rst=0 at an edge) forces, from the next cycle, regardless of state, including mid-MAC or mid-DRAIN:
  - state IDLE, accumulators 0, beat counter 0, out_col 0;
  - outputs in_ready=0, out_valid=0, out_last=0, busy=0, done=0, out_data all 0.
- start in IDLE at edge t: busy=1 and in_ready=1 from cycle t+1.
- Throughput is one MAC beat per cycle. With in_valid held high, the final beat is accepted at edge t+k_len and out_valid=1 from cycle t+k_len+1. That first drain beat already includes the final product.
- With out_ready held high, the drain takes COLS cycles. done is high the cycle after the last drain beat is accepted, and start is accepted again the cycle after that.
- in_ready, out_valid, out_last and busy are decoded from registered state only, with no combinational path from in_valid/out_ready.
- out_data is a combinational column mux of registered accumulators, selected by the registered out_col.

## Structure
- Package pe_array_pkg:
  - state enum;
  - saturating-add function parameterised by ACC_WIDTH;
  - localparam COL_W = $clog2(COLS).
- Sub-module pe_mac: one PE with signed DATA_WIDTH operands, a ACC_WIDTH saturating accumulator, and clr/en inputs. It is instantiated ROWS x COLS times in a generate loop.
- FSM, beat counter and drain mux live in the top module.

## Test plan
- Basic 3-beat run (ROWS=COLS=4), all actn_in=2, filt_in=3, k_len=3, in_valid and out_ready held high -> four drain beats, out_col 0..3, every element 18, out_last only on col 3, done one cycle later.
- Per-lane identity: actn_in[r]=r+1, filt_in[c]=-(c+1), k_len=1 -> out_data[r] on column c equals -(r+1)(c+1).
- Saturation: actn_in=127, filt_in=127, k_len=100, ACC_WIDTH=20 -> 100*16129=1,612,900 clamps to 524,287. Repeat with filt_in=-128 -> result clamps to -524,288.
- Handshake stalls: toggle in_valid randomly, k_len=5 -> exactly 5 beats accumulated. Deassert out_ready for 3 cycles on col 1 -> out_data and out_col held stable, no beat skipped.
- k_len=0 -> immediate drain of COLS beats of zeros, then done. start pulsed during DRAIN -> ignored.
- Reset mid-MAC after 2 of 4 beats -> all outputs 0 and IDLE next cycle. A new start with k_len=1 yields only that single product.
